fork_join_dispatcher: RTL and testbench
=======================================

FORK_JOIN_DISPATCHER -- requirements
Module: fork_join_dispatcher

Upstream command stage for the controller side. It accepts one command, forks two sends (A, B), joins, waits for the C response, checks it, and returns it. A watchdog flags deadlock.

Interface
REQ-001 Parameter DATA_W, default 8: width of every data field.
REQ-002 Parameter RESP_VAL, default 42: expected C response when flag > 0.
REQ-003 Parameter TIMEOUT, default 256: cycles without handshake progress before deadlock is declared.
REQ-004 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_flag  in  DATA_W  flag value to forward on B.
- a_valid  out  1 / a_ready  in  1 / a_data  out  DATA_W  channel A send.
- b_valid  out  1 / b_ready  in  1 / b_data  out  DATA_W  channel B send.
- c_valid  in  1 / c_ready  out  1 / c_data  in  DATA_W  channel C receive.
- rsp_valid  out  1 / rsp_ready  in  1 / rsp_data  out  DATA_W  response to requester.
- rsp_mismatch  out  1  qualifies rsp_data; high if the response differs from the expected value.
- deadlock  out  1  sticky watchdog flag.
- err_clr  in  1  single-cycle clear of deadlock.

Function
REQ-005 A handshake on any port SHALL occur on a rising edge with valid=1 and ready=1.
REQ-006 The FSM SHALL have the states IDLE, FORK, JOIN_C, RESP and DEADLOCK.
REQ-007 In IDLE, cmd_ready=1. A cmd handshake latches cmd_flag and moves the FSM to FORK; cmd_ready=0 in all other states.
REQ-008 FORK timing and data:
- a_valid and b_valid SHALL rise on the cycle after command acceptance.
- a_data=0.
- b_data=latched flag.
REQ-009 Each of A and B SHALL complete independently in either order. After its own handshake, that valid drops and a done bit is set.
REQ-010 FORK SHALL exit to JOIN_C on the edge where the second of A/B completes. If A and B complete on the same edge, the exit is direct.
REQ-011 In JOIN_C, c_ready=1. A C handshake captures c_data into rsp_data and moves the FSM to RESP.
REQ-012 rsp_mismatch:
- Expected value = RESP_VAL if latched flag > 0 (unsigned), else 0.
- rsp_mismatch = (captured != expected).
- Registered together with rsp_data.
REQ-013 In RESP, rsp_valid=1 and holds rsp_data stable until rsp_ready. The rsp handshake returns the FSM to IDLE.
REQ-014 Zero-stall latency: cmd accepted at edge 0; A/B handshake at edge 1; C handshake at edge 2; rsp_valid high after edge 2.
REQ-015 Watchdog scope: the watchdog counts cycles in FORK and JOIN_C.
REQ-016 Watchdog clear: the count clears on any A, B or C handshake and on entering FORK.
REQ-017 Watchdog expiry: when the count reaches TIMEOUT-1 with no handshake that cycle, the FSM SHALL enter DEADLOCK.
REQ-018 In DEADLOCK:
- deadlock=1.
- All valid and ready outputs = 0.
- Done bits clear.
- The state holds until err_clr=1, which returns the FSM to IDLE and drops deadlock the next cycle.
REQ-019 err_clr outside DEADLOCK SHALL have no effect. RESP SHALL NOT time out; stalling on rsp_ready is legal indefinitely.
REQ-020 Counter width SHALL be $clog2(TIMEOUT)+1 bits and SHALL saturate rather than wrap.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- state IDLE;
- all valids, c_ready and deadlock to 0;
- cmd_ready to 1;
- rsp_data and the latched flag to 0;
- rsp_mismatch, done bits and the watchdog count to 0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction. No partial handshake survives, and deassertion resumes in IDLE.

Structure
REQ-023 Package fork_join_pkg SHALL hold the state enum fj_state_t, the default DATA_W, RESP_VAL and TIMEOUT constants, and a function computing the expected response.
REQ-024 The watchdog SHALL be the sub-module fj_watchdog, with inputs enable/kick and output expired.
REQ-025 All outputs SHALL be registered.

Verification
REQ-026 Command flag=1 with all readies high -> a_data=0, b_data=1, then c_data=42 -> rsp_data=42, rsp_mismatch=0, rsp_valid 3 cycles after cmd.
REQ-027 Flag=0, B ready 5 cycles before A -> b_valid drops first, a_valid held until A completes, JOIN_C entered only after A, response 0 -> mismatch=0.
REQ-028 Flag=7, c_data=41 -> rsp_data=41, rsp_mismatch=1. With rsp_ready low for 1000 cycles, no deadlock and stable output.
REQ-029 TIMEOUT=16, A handshakes, B ready never asserted -> deadlock=1 exactly 16 cycles after the A handshake, all valids 0. An err_clr pulse returns cmd_ready=1.
REQ-030 rst_n pulsed low while in JOIN_C -> immediate outputs at reset values. The next command completes normally.

Source files
------------

// File: rtl/fork_join_pkg.sv
// Purpose: shared types, defaults and the expected-response rule for the fork/join dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fork_join_pkg;

   localparam int FJ_DATA_W   = 8;
   localparam int FJ_RESP_VAL = 42;
   localparam int FJ_TIMEOUT  = 256;

   typedef enum logic [2:0] {
      IDLE,
      FORK,
      JOIN_C,
      RESP,
      DEADLOCK
   } fj_state_t;

   // A non-zero flag asks the far side for resp_val; a zero flag expects zero back.
   function automatic logic [31:0] fj_expected(input logic [31:0] flag,
                                               input logic [31:0] resp_val);
      return (flag != 32'd0) ? resp_val : 32'd0;
   endfunction

endpackage

// File: rtl/fj_watchdog.sv
// Purpose: counts idle cycles while enabled and flags expiry at TIMEOUT-1 without a kick.
// Latency: expired is combinational from the registered count; count updates each edge.
// Backpressure: none; kick clears, disable clears, count saturates instead of wrapping.
// Ports: clk, rst_n (async active-low), enable (count allowed), kick (progress seen),
//        expired (count at limit this cycle with no kick).
module fj_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (kick || !enable) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = enable && !kick && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fork_join_dispatcher.sv
// Purpose: accepts one command, forks sends on A and B, joins, collects C, returns it checked.
// Latency: zero-stall cmd edge 0, A/B edge 1, C edge 2, rsp_valid after edge 2.
// Backpressure: one command in flight; cmd_ready low until rsp handshake; watchdog on A/B/C waits.
// Ports: cmd_* command in, a_*/b_* fork sends, c_* join receive, rsp_* checked response out,
//        deadlock sticky watchdog flag, err_clr clears it. DATA_W must be 32 or less.
module fork_join_dispatcher
   import fork_join_pkg::*;
#(
   parameter int DATA_W   = FJ_DATA_W,
   parameter int RESP_VAL = FJ_RESP_VAL,
   parameter int TIMEOUT  = FJ_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_flag,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] a_data,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [DATA_W-1:0] b_data,
   input  logic              c_valid,
   output logic              c_ready,
   input  logic [DATA_W-1:0] c_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_mismatch,
   output logic              deadlock,
   input  logic              err_clr
);

   fj_state_t         state, nxt;
   logic              a_done, b_done, a_done_nxt, b_done_nxt;
   logic [DATA_W-1:0] flag;
   logic [DATA_W-1:0] exp_rsp;
   logic              cmd_hs, a_hs, b_hs, c_hs, rsp_hs;
   logic              wd_en, wd_expired;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign a_hs   = a_valid && a_ready;
   assign b_hs   = b_valid && b_ready;
   assign c_hs   = c_valid && c_ready;
   assign rsp_hs = rsp_valid && rsp_ready;

   assign a_data  = '0;
   assign b_data  = flag;
   assign exp_rsp = DATA_W'(fj_expected(32'(flag), 32'(RESP_VAL)));

   // Watchdog only runs while waiting on the far side; entering FORK counts as progress.
   assign wd_en = (state == FORK) || (state == JOIN_C);

   fj_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (wd_en),
      .kick    (cmd_hs || a_hs || b_hs || c_hs),
      .expired (wd_expired)
   );

   always_comb begin
      nxt        = state;
      a_done_nxt = 1'b0;
      b_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_hs) nxt = FORK;
         end
         FORK: begin
            if (wd_expired) begin
               nxt = DEADLOCK;
            end else begin
               a_done_nxt = a_done || a_hs;
               b_done_nxt = b_done || b_hs;
               // Join on the edge the later of the two completes (or both together).
               if (a_done_nxt && b_done_nxt) begin
                  nxt        = JOIN_C;
                  a_done_nxt = 1'b0;
                  b_done_nxt = 1'b0;
               end
            end
         end
         JOIN_C: begin
            if (wd_expired) nxt = DEADLOCK;
            else if (c_hs)  nxt = RESP;
         end
         RESP: begin
            if (rsp_hs) nxt = IDLE;
         end
         DEADLOCK: begin
            if (err_clr) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_done       <= 1'b0;
         b_done       <= 1'b0;
         flag         <= '0;
         rsp_data     <= '0;
         rsp_mismatch <= 1'b0;
         cmd_ready    <= 1'b1;
         a_valid      <= 1'b0;
         b_valid      <= 1'b0;
         c_ready      <= 1'b0;
         rsp_valid    <= 1'b0;
         deadlock     <= 1'b0;
      end else begin
         state     <= nxt;
         a_done    <= a_done_nxt;
         b_done    <= b_done_nxt;
         cmd_ready <= (nxt == IDLE);
         a_valid   <= (nxt == FORK) && !a_done_nxt;
         b_valid   <= (nxt == FORK) && !b_done_nxt;
         c_ready   <= (nxt == JOIN_C);
         rsp_valid <= (nxt == RESP);
         deadlock  <= (nxt == DEADLOCK);
         if (cmd_hs) flag <= cmd_flag;
         if (c_hs) begin
            rsp_data     <= c_data;
            rsp_mismatch <= (c_data != exp_rsp);
         end
      end
   end

endmodule

// File: tb/tb_fork_join_dispatcher.sv
module tb_fork_join_dispatcher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [7:0] cmd_flag;
   logic       a_valid, a_ready, b_valid, b_ready;
   logic [7:0] a_data, b_data;
   logic       c_valid, c_ready;
   logic [7:0] c_data;
   logic       rsp_valid, rsp_ready, rsp_mismatch;
   logic [7:0] rsp_data;
   logic       deadlock, err_clr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fork_join_dispatcher #(.DATA_W(8), .RESP_VAL(42), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_flag     (cmd_flag),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_data       (b_data),
      .c_valid      (c_valid),
      .c_ready      (c_ready),
      .c_data       (c_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_mismatch (rsp_mismatch),
      .deadlock     (deadlock),
      .err_clr      (err_clr)
   );

   typedef struct {
      logic [7:0] flag;
      logic [7:0] cdat;
      logic [7:0] exp_rsp;
      logic       exp_mis;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      cmd_valid = 1'b0;
      cmd_flag  = 8'd0;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      c_valid   = 1'b0;
      c_data    = 8'd0;
      rsp_ready = 1'b0;
      err_clr   = 1'b0;
   endtask

   // Zero-stall transaction with optional response stall before rsp_ready.
   task automatic run_vec(input logic [7:0] f, input logic [7:0] cd, input logic [7:0] er,
                          input logic em, input int stall);
      int bad;
      cmd_flag  = f;
      cmd_valid = 1'b1;
      a_ready   = 1'b1;
      b_ready   = 1'b1;
      c_valid   = 1'b1;
      c_data    = cd;
      chk("vec_cmd_ready", cmd_ready, 1);
      tick();                                   // edge 0: command accepted
      cmd_valid = 1'b0;
      chk("vec_fork_valids", {cmd_ready, a_valid, b_valid}, 3'b011);
      chk("vec_a_data", a_data, 0);
      chk("vec_b_data", b_data, f);
      tick();                                   // edge 1: A and B together
      chk("vec_join", {a_valid, b_valid, c_ready}, 3'b001);
      tick();                                   // edge 2: C captured
      c_valid = 1'b0;
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_data", rsp_data, er);
      chk("vec_rsp_mismatch", rsp_mismatch, em);
      bad = 0;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== er || rsp_mismatch !== em || deadlock !== 1'b0)
            bad++;
      end
      if (stall > 0) chk("vec_rsp_stall_stable", bad, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      chk("vec_back_idle", {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      int bad;
      logic       busy, a_seen, b_seen, c_seen;
      logic [7:0] cur_flag, exp_val, got_c;
      int         n_done;

      vecs[0] = '{flag: 8'd1,   cdat: 8'd42, exp_rsp: 8'd42, exp_mis: 1'b0};
      vecs[1] = '{flag: 8'd0,   cdat: 8'd0,  exp_rsp: 8'd0,  exp_mis: 1'b0};
      vecs[2] = '{flag: 8'd7,   cdat: 8'd41, exp_rsp: 8'd41, exp_mis: 1'b1};
      vecs[3] = '{flag: 8'd0,   cdat: 8'd5,  exp_rsp: 8'd5,  exp_mis: 1'b1};
      vecs[4] = '{flag: 8'd255, cdat: 8'd42, exp_rsp: 8'd42, exp_mis: 1'b0};
      vecs[5] = '{flag: 8'd128, cdat: 8'd0,  exp_rsp: 8'd0,  exp_mis: 1'b1};

      set_idle();
      rst_n = 1'b0;
      #12;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_valids", {a_valid, b_valid, c_ready, rsp_valid}, 0);
      chk("rst_deadlock", deadlock, 0);
      chk("rst_rsp", {rsp_data, rsp_mismatch}, 0);
      chk("rst_b_data", b_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i].flag, vecs[i].cdat, vecs[i].exp_rsp, vecs[i].exp_mis, 0);

      // B ready five cycles before A; join waits for A.
      cmd_flag  = 8'd0;
      cmd_valid = 1'b1;
      b_ready   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("skew_fork", {a_valid, b_valid}, 2'b11);
      tick();
      chk("skew_b_first", {a_valid, b_valid, c_ready}, 3'b100);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({a_valid, b_valid, c_ready} !== 3'b100) bad++;
      end
      chk("skew_a_held", bad, 0);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      b_ready = 1'b0;
      chk("skew_join_after_a", {a_valid, b_valid, c_ready}, 3'b001);
      c_valid = 1'b1;
      c_data  = 8'd0;
      tick();
      c_valid = 1'b0;
      chk("skew_rsp", {rsp_valid, rsp_data, rsp_mismatch}, {1'b1, 8'd0, 1'b0});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Long response stall must not trip the watchdog.
      run_vec(8'd7, 8'd41, 8'd41, 1'b1, 1000);

      // B never ready: deadlock 16 cycles after the A handshake.
      cmd_flag  = 8'd3;
      cmd_valid = 1'b1;
      a_ready   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();                                   // A handshake edge
      a_ready = 1'b0;
      chk("wd_a_done", {a_valid, b_valid}, 2'b01);
      bad = 0;
      for (int i = 1; i <= 15; i++) begin
         if (i == 5) err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         if (deadlock !== 1'b0) bad++;
      end
      chk("wd_no_early_deadlock", bad, 0);
      chk("wd_errclr_no_effect", b_valid, 1);
      tick();
      chk("wd_deadlock", deadlock, 1);
      chk("wd_outputs_low", {cmd_ready, a_valid, b_valid, c_ready, rsp_valid}, 0);
      b_ready = 1'b1;
      repeat (3) tick();
      b_ready = 1'b0;
      chk("wd_sticky", deadlock, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("wd_cleared", {deadlock, cmd_ready}, 2'b01);

      // Asynchronous reset while waiting in JOIN_C.
      cmd_flag  = 8'd9;
      cmd_valid = 1'b1;
      a_ready   = 1'b1;
      b_ready   = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("rstmid_in_join", c_ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_outputs", {cmd_ready, a_valid, b_valid, c_ready, rsp_valid, deadlock}, 6'b100000);
      chk("rstmid_flag", b_data, 0);
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_vec(8'd9, 8'd42, 8'd42, 1'b0, 0);

      // Randomized traffic against a transaction-level model.
      busy = 1'b0; a_seen = 1'b0; b_seen = 1'b0; c_seen = 1'b0;
      cur_flag = 8'd0; exp_val = 8'd0; got_c = 8'd0; n_done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_flag  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         a_ready   = ($urandom_range(0, 3) != 0);
         b_ready   = ($urandom_range(0, 3) != 0);
         c_valid   = ($urandom_range(0, 3) != 0);
         c_data    = ($urandom_range(0, 1) == 1) ? exp_val : 8'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         chk("rnd_ctrl", {cmd_ready, a_valid, b_valid, c_ready, rsp_valid, deadlock},
             {!busy, busy && !a_seen, busy && !b_seen,
              busy && a_seen && b_seen && !c_seen, c_seen, 1'b0});
         if (cmd_valid && cmd_ready) begin
            busy = 1'b1; a_seen = 1'b0; b_seen = 1'b0; c_seen = 1'b0;
            cur_flag = cmd_flag;
            exp_val  = (cmd_flag != 8'd0) ? 8'd42 : 8'd0;
         end
         if (a_valid && a_ready) begin
            chk("rnd_a_data", a_data, 0);
            a_seen = 1'b1;
         end
         if (b_valid && b_ready) begin
            chk("rnd_b_data", b_data, cur_flag);
            b_seen = 1'b1;
         end
         if (c_valid && c_ready) begin
            c_seen = 1'b1;
            got_c  = c_data;
         end
         if (rsp_valid && rsp_ready) begin
            chk("rnd_rsp_data", rsp_data, got_c);
            chk("rnd_rsp_mismatch", rsp_mismatch, got_c != exp_val);
            busy = 1'b0; c_seen = 1'b0;
            n_done++;
         end
      end
      chk("rnd_progress", n_done > 50, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
